// File: rtl/tl_get_arbiter.sv
// Round-robin arbiter sharing one TileLink-UL master port (A/D) among N read requesters.
// Full-word Get only, one transaction in flight. Define TL_ARB_TIMEOUT_EN for the D-channel watchdog.
module tl_get_arbiter #(
    parameter int unsigned N       = 2,
    parameter int unsigned W       = 4,
    parameter int unsigned A       = 32,
    parameter int unsigned Z       = 32,
    parameter int unsigned O       = 1,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [N-1:0]     req_valid_i,
    output logic [N-1:0]     req_ready_o,
    input  logic [N*A-1:0]   req_addr_i,
    output logic [N-1:0]     rsp_valid_o,
    output logic [8*W-1:0]   rsp_data_o,
    output logic             rsp_error_o,
    output logic [2:0]       a_opcode_o,
    output logic [2:0]       a_param_o,
    output logic [Z-1:0]     a_size_o,
    output logic [O-1:0]     a_source_o,
    output logic [A-1:0]     a_address_o,
    output logic [W-1:0]     a_mask_o,
    output logic             a_valid_o,
    input  logic             a_ready_i,
    input  logic [2:0]       d_opcode_i,
    input  logic [O-1:0]     d_source_i,
    input  logic [8*W-1:0]   d_data_i,
    input  logic             d_error_i,
    input  logic             d_valid_i,
    output logic             d_ready_o
);
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StASend, StDWait} state_e;

    state_e           r_state;
    logic [PW-1:0]    r_rr_ptr;
    logic [PW-1:0]    r_grant;
    logic [A-1:0]     r_addr;
    logic [O-1:0]     r_source;
    logic             r_a_valid;
    logic [N-1:0]     r_rsp_valid;
    logic [8*W-1:0]   r_rsp_data;
    logic             r_rsp_error;

    logic             w_grant_vld;
    logic [PW-1:0]    w_grant_idx;
    logic [A-1:0]     w_grant_addr;
    logic             w_accept;
    logic             w_d_match;
    logic             w_timeout;
    logic [N-1:0]     w_grant_onehot;

    // Round-robin scan starting just after the last served requester.
    always_comb begin
        logic [PW:0] v_idx;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        v_idx       = '0;
        for (int i = 1; i <= int'(N); i++) begin
            v_idx = {1'b0, r_rr_ptr} + (PW+1)'(i);
            if (v_idx >= (PW+1)'(N)) begin
                v_idx = v_idx - (PW+1)'(N);
            end
            if (!w_grant_vld && req_valid_i[v_idx[PW-1:0]]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = v_idx[PW-1:0];
            end
        end
    end

    always_comb begin
        w_grant_addr = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (PW'(k) == w_grant_idx) begin
                w_grant_addr = req_addr_i[k*A +: A];
            end
        end
    end

    // A response pulse blocks the grant for one cycle so the requester sees it first.
    assign w_accept       = (r_state == StIdle) && !reset_i && !(|r_rsp_valid) && w_grant_vld;
    assign req_ready_o    = w_accept ? (N'(1) << w_grant_idx) : '0;
    assign w_d_match      = d_valid_i && (d_source_i == r_source);
    assign w_grant_onehot = N'(1) << r_grant;

`ifdef TL_ARB_TIMEOUT_EN
    localparam int unsigned CntW   = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    // Fire point chosen so the error pulse lands TIMEOUT cycles after the A handshake.
    localparam int unsigned FireAt = (TIMEOUT >= 2) ? TIMEOUT - 2 : 0;

    logic [CntW-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_cnt <= '0;
        end else if (r_state != StDWait) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CntW'(1);
        end
    end

    assign w_timeout = (r_state == StDWait) && (r_cnt == CntW'(FireAt));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= StIdle;
            r_rr_ptr    <= PW'(N - 1);
            r_grant     <= '0;
            r_addr      <= '0;
            r_source    <= '0;
            r_a_valid   <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_error <= 1'b0;
        end else begin
            r_rsp_valid <= '0;
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_grant   <= w_grant_idx;
                        r_addr    <= w_grant_addr;
                        r_source  <= O'(w_grant_idx);
                        r_a_valid <= 1'b1;
                        r_state   <= StASend;
                    end
                end
                StASend: begin
                    if (a_ready_i) begin
                        r_a_valid <= 1'b0;
                        r_state   <= StDWait;
                    end
                end
                StDWait: begin
                    // A matching beat takes priority over a simultaneous timeout.
                    if (w_d_match) begin
                        r_rsp_valid <= w_grant_onehot;
                        r_rsp_data  <= d_data_i;
                        r_rsp_error <= d_error_i | (d_opcode_i != 3'd1);
                        r_rr_ptr    <= r_grant;
                        r_state     <= StIdle;
                    end else if (w_timeout) begin
                        r_rsp_valid <= w_grant_onehot;
                        r_rsp_data  <= '0;
                        r_rsp_error <= 1'b1;
                        r_rr_ptr    <= r_grant;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign rsp_valid_o = r_rsp_valid;
    assign rsp_data_o  = r_rsp_data;
    assign rsp_error_o = r_rsp_error;
    assign a_opcode_o  = 3'd4;
    assign a_param_o   = 3'd0;
    assign a_size_o    = Z'($clog2(W));
    assign a_source_o  = r_source;
    assign a_address_o = r_addr;
    assign a_mask_o    = '1;
    assign a_valid_o   = r_a_valid;
    // D beats are always sunk; unsolicited or foreign-source beats are simply ignored.
    assign d_ready_o   = !reset_i;

endmodule

// File: tb/tb_tl_get_arbiter.sv
// Self-checking bench for tl_get_arbiter: scenario tasks with a response scoreboard queue.
// Timeout scenario runs only when TL_ARB_TIMEOUT_EN is defined.
module tb_tl_get_arbiter;
    localparam int unsigned N  = 2;
    localparam int unsigned W  = 4;
    localparam int unsigned A  = 32;
    localparam int unsigned Z  = 32;
    localparam int unsigned O  = 1;
    localparam int unsigned TO = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*A-1:0]   req_addr;
    logic [N-1:0]     rsp_valid;
    logic [8*W-1:0]   rsp_data;
    logic             rsp_error;
    logic [2:0]       a_opcode;
    logic [2:0]       a_param;
    logic [Z-1:0]     a_size;
    logic [O-1:0]     a_source;
    logic [A-1:0]     a_address;
    logic [W-1:0]     a_mask;
    logic             a_valid;
    logic             a_ready;
    logic [2:0]       d_opcode;
    logic [O-1:0]     d_source;
    logic [8*W-1:0]   d_data;
    logic             d_error;
    logic             d_valid;
    logic             d_ready;

    typedef struct packed {
        logic [N-1:0]   vld;
        logic [8*W-1:0] data;
        logic           err;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    tl_get_arbiter #(.N(N), .W(W), .A(A), .Z(Z), .O(O), .TIMEOUT(TO)) u_dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_addr_i (req_addr),
        .rsp_valid_o(rsp_valid),
        .rsp_data_o (rsp_data),
        .rsp_error_o(rsp_error),
        .a_opcode_o (a_opcode),
        .a_param_o  (a_param),
        .a_size_o   (a_size),
        .a_source_o (a_source),
        .a_address_o(a_address),
        .a_mask_o   (a_mask),
        .a_valid_o  (a_valid),
        .a_ready_i  (a_ready),
        .d_opcode_i (d_opcode),
        .d_source_i (d_source),
        .d_data_i   (d_data),
        .d_error_i  (d_error),
        .d_valid_i  (d_valid),
        .d_ready_o  (d_ready)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [N-1:0] vld, input logic [8*W-1:0] data, input logic err);
        exp_t e;
        e.vld  = vld;
        e.data = data;
        e.err  = err;
        sb_q.push_back(e);
    endtask

    function automatic exp_t pop_exp();
        exp_t e;
        e = '0;
        if (sb_q.size() > 0) e = sb_q.pop_front();
        return e;
    endfunction

    task automatic wait_grant(output logic [N-1:0] rdy, output bit ok);
        int cnt = 0;
        ok  = 1'b0;
        rdy = '0;
        while (!ok && cnt < 20) begin
            @(negedge clk);
            cnt++;
            if (|req_ready) begin
                rdy = req_ready;
                ok  = 1'b1;
            end
        end
    endtask

    task automatic wait_a(output bit ok);
        int cnt = 0;
        ok = 1'b0;
        while (!ok && cnt < 20) begin
            @(negedge clk);
            cnt++;
            if (a_valid) ok = 1'b1;
        end
    endtask

    task automatic wait_rsp(output logic [N-1:0] vld, output logic [8*W-1:0] data,
                            output logic err, output bit ok);
        int cnt = 0;
        ok   = 1'b0;
        vld  = '0;
        data = '0;
        err  = 1'b0;
        while (!ok && cnt < 40) begin
            @(negedge clk);
            cnt++;
            if (|rsp_valid) begin
                vld  = rsp_valid;
                data = rsp_data;
                err  = rsp_error;
                ok   = 1'b1;
            end
        end
    endtask

    // One D beat, driven for exactly one cycle starting after the next rising edge.
    task automatic drive_d(input logic [O-1:0] src, input logic [8*W-1:0] data,
                           input logic err, input logic [2:0] op);
        cyc();
        d_valid  = 1'b1;
        d_source = src;
        d_data   = data;
        d_error  = err;
        d_opcode = op;
        cyc();
        d_valid  = 1'b0;
    endtask

    // Raise a one-cycle request, wait for its grant and for A to go valid.
    task automatic issue(input logic [N-1:0] vld, input logic [A-1:0] addr,
                         output logic [N-1:0] rdy, output bit ok);
        bit ok_g;
        bit ok_a;
        cyc();
        req_valid = vld;
        for (int k = 0; k < int'(N); k++) begin
            if (vld[k]) req_addr[k*A +: A] = addr;
        end
        wait_grant(rdy, ok_g);
        cyc();
        req_valid = '0;
        wait_a(ok_a);
        ok = ok_g && ok_a;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        a_ready   = 1'b0;
        d_valid   = 1'b0;
        repeat (2) cyc();
        reset = 1'b0;
        sb_q.delete();
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 2'b11;
        req_addr  = {32'h0000_0abc, 32'h0000_0def};
        a_ready   = 1'b0;
        d_valid   = 1'b0;
        d_source  = '0;
        d_data    = '0;
        d_error   = 1'b0;
        d_opcode  = 3'd1;
        repeat (3) cyc();
        @(negedge clk);
        n_tests++;
        if (req_ready !== 2'b00) begin
            n_fail++; $display("FAIL reset_req_ready: got %b want 00", req_ready);
        end
        n_tests++;
        if (a_valid !== 1'b0 || a_source !== 1'b0 || a_address !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_a: got valid=%b src=%h addr=%h want 0/0/0", a_valid, a_source,
                     a_address);
        end
        n_tests++;
        if (rsp_valid !== 2'b00 || rsp_data !== 32'h0 || rsp_error !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rsp: got vld=%b data=%h err=%b want 00/0/0", rsp_valid, rsp_data,
                     rsp_error);
        end
        cyc();
        reset     = 1'b0;
        req_valid = '0;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 2'b00 || a_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: got ready=%b a_valid=%b want 00/0", req_ready, a_valid);
        end
    endtask

    task automatic test_single();
        exp_t e;
        cyc();
        req_valid       = 2'b01;
        req_addr[31:0]  = 32'h0000_0100;
        a_ready         = 1'b1;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 2'b01) begin
            n_fail++; $display("FAIL single_grant: got %b want 01", req_ready);
        end
        cyc();
        req_valid = '0;
        @(negedge clk);
        n_tests++;
        if (a_valid !== 1'b1 || a_opcode !== 3'd4 || a_param !== 3'd0 || a_size !== 32'd2 ||
            a_mask !== 4'hf || a_source !== 1'b0 || a_address !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL single_a: got v=%b op=%0d par=%0d sz=%0d m=%h src=%0d addr=%h want 1/4/0/2/f/0/100",
                     a_valid, a_opcode, a_param, a_size, a_mask, a_source, a_address);
        end
        cyc();
        push_exp(2'b01, 32'hdead_beef, 1'b0);
        d_valid = 1'b1; d_source = 1'b0; d_data = 32'hdead_beef; d_error = 1'b0; d_opcode = 3'd1;
        @(negedge clk);
        n_tests++;
        if (d_ready !== 1'b1 || a_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_dwait: got d_ready=%b a_valid=%b want 1/0", d_ready, a_valid);
        end
        cyc();
        d_valid = 1'b0;
        @(negedge clk);
        e = pop_exp();
        n_tests++;
        if (rsp_valid !== e.vld || rsp_data !== e.data || rsp_error !== e.err) begin
            n_fail++;
            $display("FAIL single_rsp_c3: got vld=%b data=%h err=%b want %b/%h/%b", rsp_valid,
                     rsp_data, rsp_error, e.vld, e.data, e.err);
        end
        cyc();
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 2'b00) begin
            n_fail++; $display("FAIL single_rsp_pulse: got %b in c4 want 00", rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        int             exp_g[4];
        logic [N-1:0]   rdy;
        logic [N-1:0]   vld;
        logic [8*W-1:0] data;
        logic           err;
        bit             ok;
        exp_t           e;
        exp_g = '{0, 1, 0, 1};
        do_reset();
        req_addr  = {32'h0000_0300, 32'h0000_0200};
        req_valid = 2'b11;
        a_ready   = 1'b1;
        for (int t = 0; t < 4; t++) begin
            wait_grant(rdy, ok);
            n_tests++;
            if (!ok || rdy !== (N'(1) << exp_g[t])) begin
                n_fail++; $display("FAIL rr_grant%0d: got %b want %b", t, rdy, N'(1) << exp_g[t]);
            end
            wait_a(ok);
            n_tests++;
            if (!ok || a_source !== O'(exp_g[t]) ||
                a_address !== ((exp_g[t] == 1) ? 32'h0000_0300 : 32'h0000_0200)) begin
                n_fail++;
                $display("FAIL rr_a%0d: got ok=%0b src=%0d addr=%h want src=%0d", t, ok, a_source,
                         a_address, exp_g[t]);
            end
            push_exp(N'(1) << exp_g[t], 32'ha5a5_0000 + 32'(t), 1'b0);
            drive_d(O'(exp_g[t]), 32'ha5a5_0000 + 32'(t), 1'b0, 3'd1);
            wait_rsp(vld, data, err, ok);
            e = pop_exp();
            n_tests++;
            if (!ok || vld !== e.vld || data !== e.data || err !== e.err) begin
                n_fail++;
                $display("FAIL rr_rsp%0d: got ok=%0b vld=%b data=%h err=%b want %b/%h/%b", t, ok,
                         vld, data, err, e.vld, e.data, e.err);
            end
        end
        cyc();
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        logic [N-1:0]   rdy;
        logic [N-1:0]   vld;
        logic [8*W-1:0] data;
        logic           err;
        bit             ok;
        exp_t           e;
        cyc();
        req_valid        = 2'b10;
        req_addr[63:32]  = 32'h4444_0000;
        a_ready          = 1'b0;
        wait_grant(rdy, ok);
        n_tests++;
        if (!ok || rdy !== 2'b10) begin
            n_fail++; $display("FAIL bp_grant: got %b want 10", rdy);
        end
        cyc();
        req_valid = '0;
        req_addr  = '1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (a_valid !== 1'b1 || a_address !== 32'h4444_0000 || a_source !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got v=%b addr=%h src=%0d want 1/44440000/1", i, a_valid,
                         a_address, a_source);
            end
        end
        cyc();
        a_ready = 1'b1;
        push_exp(2'b10, 32'h1234_5678, 1'b0);
        drive_d(1'b1, 32'h1234_5678, 1'b0, 3'd1);
        wait_rsp(vld, data, err, ok);
        e = pop_exp();
        n_tests++;
        if (!ok || vld !== e.vld || data !== e.data || err !== e.err) begin
            n_fail++;
            $display("FAIL bp_rsp: got ok=%0b vld=%b data=%h err=%b want %b/%h/%b", ok, vld, data,
                     err, e.vld, e.data, e.err);
        end
    endtask

    task automatic test_errors();
        logic [N-1:0]   rdy;
        logic [N-1:0]   vld;
        logic [8*W-1:0] data;
        logic           err;
        bit             ok;
        exp_t           e;
        logic [2:0]     ops[2];
        logic           errs[2];
        ops  = '{3'd1, 3'd0};
        errs = '{1'b1, 1'b0};
        a_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            issue(2'b01, 32'h0000_0500, rdy, ok);
            push_exp(2'b01, 32'h1111_0000 + 32'(c), 1'b1);
            drive_d(1'b0, 32'h1111_0000 + 32'(c), errs[c], ops[c]);
            wait_rsp(vld, data, err, ok);
            e = pop_exp();
            n_tests++;
            if (!ok || vld !== e.vld || data !== e.data || err !== e.err) begin
                n_fail++;
                $display("FAIL err_case%0d: got ok=%0b vld=%b data=%h err=%b want %b/%h/%b", c, ok,
                         vld, data, err, e.vld, e.data, e.err);
            end
        end
        issue(2'b01, 32'h0000_0600, rdy, ok);
        drive_d(1'b1, 32'hbad0_bad0, 1'b0, 3'd1);
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 2'b00) begin
            n_fail++; $display("FAIL err_wrong_src: got rsp_valid=%b want 00", rsp_valid);
        end
        push_exp(2'b01, 32'h600d_f00d, 1'b0);
        drive_d(1'b0, 32'h600d_f00d, 1'b0, 3'd1);
        wait_rsp(vld, data, err, ok);
        e = pop_exp();
        n_tests++;
        if (!ok || vld !== e.vld || data !== e.data || err !== e.err) begin
            n_fail++;
            $display("FAIL err_after_drop: got ok=%0b vld=%b data=%h err=%b want %b/%h/%b", ok, vld,
                     data, err, e.vld, e.data, e.err);
        end
        drive_d(1'b0, 32'hffff_0000, 1'b0, 3'd1);
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 2'b00 || d_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL err_unsolicited: got rsp_valid=%b d_ready=%b want 00/1", rsp_valid, d_ready);
        end
    endtask

`ifdef TL_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [N-1:0]   rdy;
        logic [N-1:0]   vld;
        logic [8*W-1:0] data;
        logic           err;
        bit             ok;
        bit             early;
        exp_t           e;
        a_ready = 1'b1;
        issue(2'b01, 32'h0000_0700, rdy, ok);
        push_exp(2'b01, 32'h0, 1'b1);
        early = 1'b0;
        for (int k = 1; k < int'(TO); k++) begin
            @(negedge clk);
            if (rsp_valid !== 2'b00) early = 1'b1;
        end
        n_tests++;
        if (!ok || early) begin
            n_fail++; $display("FAIL to_early: got ok=%0b early_pulse=%0b want 1/0", ok, early);
        end
        @(negedge clk);
        e = pop_exp();
        n_tests++;
        if (rsp_valid !== e.vld || rsp_data !== e.data || rsp_error !== e.err) begin
            n_fail++;
            $display("FAIL to_rsp: got vld=%b data=%h err=%b want %b/%h/%b", rsp_valid, rsp_data,
                     rsp_error, e.vld, e.data, e.err);
        end
        drive_d(1'b0, 32'hcafe_f00d, 1'b0, 3'd1);
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 2'b00) begin
            n_fail++; $display("FAIL to_late_d: got rsp_valid=%b want 00", rsp_valid);
        end
        issue(2'b01, 32'h0000_0704, rdy, ok);
        push_exp(2'b01, 32'h7777_7777, 1'b0);
        drive_d(1'b0, 32'h7777_7777, 1'b0, 3'd1);
        wait_rsp(vld, data, err, ok);
        e = pop_exp();
        n_tests++;
        if (!ok || vld !== e.vld || data !== e.data || err !== e.err) begin
            n_fail++;
            $display("FAIL to_next: got ok=%0b vld=%b data=%h err=%b want %b/%h/%b", ok, vld, data,
                     err, e.vld, e.data, e.err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_errors();
`ifdef TL_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, required to finish earlier");
        $fatal(1);
    end

endmodule
